// File: rtl/mem_responder_if.sv
// Load/store request and response channel between a requester and mem_responder.
interface mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/mem_responder.sv
// Word-addressed data memory behind a valid/ready request channel, with a
// programmable access latency and a response held under backpressure.
module mem_responder #(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input  logic           clk,
  input  logic           rst,
  mem_responder_if.slave bus,
  output logic           busy
);

  localparam int          AW    = $clog2(DEPTH);
  localparam logic [31:0] BYTES = 32'(DEPTH * 4);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic          commit;
  logic          c_we;
  logic          c_err;
  logic          mem_we;
  logic [31:0]   c_addr;
  logic [31:0]   c_wdata;
  logic [AW-1:0] c_idx;

  logic [31:0] mem [DEPTH];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    commit  = 1'b0;
    c_we    = we_q;
    c_addr  = addr_q;
    c_wdata = wdata_q;

    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          we_d    = bus.req_we;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          // A single-cycle build commits on the accept edge itself.
          if (LATENCY == 1) begin
            state_d = RESP;
            commit  = 1'b1;
            c_we    = bus.req_we;
            c_addr  = bus.req_addr;
            c_wdata = bus.req_wdata;
          end else begin
            state_d = WAIT;
            cnt_d   = 4'(LATENCY - 1);
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = RESP;
          commit  = 1'b1;
        end
      end
      RESP: begin
        if (bus.resp_ready) begin
          state_d = IDLE;
          rdata_d = 32'd0;
          err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    c_err = (c_addr[1:0] != 2'b00) || (c_addr >= BYTES);
    c_idx = c_addr[AW+1:2];

    if (commit) begin
      err_d   = c_err;
      rdata_d = (c_err || c_we) ? 32'd0 : mem[c_idx];
    end

    mem_we = commit && c_we && !c_err && !rst;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Storage is deliberately left out of reset so contents survive it.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[c_idx] <= c_wdata;
    end
  end

  assign bus.req_ready  = (state_q == IDLE) && !rst;
  assign bus.resp_valid = (state_q == RESP);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;
  assign busy           = (state_q != IDLE);

endmodule
